// File: rtl/note_player_pkg.sv
// note_player_pkg: shared widths, FSM state encoding and octave base steps for the note player and song reader
package note_player_pkg;
  localparam int NOTE_WIDTH     = 6;
  localparam int DURATION_WIDTH = 6;
  localparam int STEP_WIDTH     = 20;
  localparam int PHASE_WIDTH    = 22;
  typedef enum logic {IDLE = 1'b0, PLAYING = 1'b1} state_e;
  // Phase steps for the lowest octave (A1 = 55 Hz upward) at 48 kHz with a 22-bit accumulator.
  function automatic logic [14:0] base_step(input logic [3:0] semi);
    case (semi)
      4'd0:    return 15'd4806;
      4'd1:    return 15'd5092;
      4'd2:    return 15'd5394;
      4'd3:    return 15'd5715;
      4'd4:    return 15'd6055;
      4'd5:    return 15'd6415;
      4'd6:    return 15'd6797;
      4'd7:    return 15'd7201;
      4'd8:    return 15'd7629;
      4'd9:    return 15'd8083;
      4'd10:   return 15'd8563;
      4'd11:   return 15'd9072;
      default: return 15'd0;
    endcase
  endfunction
endpackage

// File: rtl/note_player_frequency_rom.sv
// frequency_rom: 64-entry note-to-phase-step table; address 0 (rest) gives step 0
//   addr_i : note index
//   step_o : phase increment per sample
module frequency_rom
  import note_player_pkg::*;
(
  input  logic [NOTE_WIDTH-1:0] addr_i,
  output logic [STEP_WIDTH-1:0] step_o
);
  logic [NOTE_WIDTH-1:0] idx;
  logic [3:0] semi;
  logic [2:0] oct;
  // Notes 1..63 map to 12 semitones per octave; each octave doubles the step.
  always_comb begin
    idx    = addr_i - NOTE_WIDTH'(1);
    semi   = 4'(idx % 6'd12);
    oct    = 3'(idx / 6'd12);
    step_o = (addr_i == '0) ? '0 : STEP_WIDTH'(base_step(semi)) << oct;
  end
endmodule

// File: rtl/note_player.sv
// note_player: one voice that holds a note for a number of beats and advances its phase accumulator
//   clk, reset (async active-low)
//   play_enable, note, duration, load_new_note, beat, generate_next_sample : control inputs
//   done, note_active, phase, sample_tick : voice status and phase output
module note_player
  import note_player_pkg::*;
(
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      play_enable,
  input  logic [NOTE_WIDTH-1:0]     note,
  input  logic [DURATION_WIDTH-1:0] duration,
  input  logic                      load_new_note,
  input  logic                      beat,
  input  logic                      generate_next_sample,
  output logic                      done,
  output logic                      note_active,
  output logic [PHASE_WIDTH-1:0]    phase,
  output logic                      sample_tick
);
  state_e                    state_q;
  logic [NOTE_WIDTH-1:0]     note_q;
  logic [DURATION_WIDTH-1:0] remaining_q;
  logic [PHASE_WIDTH-1:0]    phase_q;
  logic                      sample_tick_q;
  logic [STEP_WIDTH-1:0]     freq_step;

  frequency_rom u_rom (.addr_i(note_q), .step_o(freq_step));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      note_q        <= '0;
      remaining_q   <= '0;
      phase_q       <= '0;
      sample_tick_q <= 1'b0;
    end else begin
      sample_tick_q <= 1'b0;
      case (state_q)
        IDLE: if (load_new_note && duration != '0) begin
          note_q      <= note;
          remaining_q <= duration;
          phase_q     <= '0;
          state_q     <= PLAYING;
        end
        PLAYING: begin
          if (beat && play_enable) begin
            remaining_q <= remaining_q - DURATION_WIDTH'(1);
            if (remaining_q == DURATION_WIDTH'(1)) state_q <= IDLE;
          end
          // The last beat's edge still applies its phase update.
          if (generate_next_sample && play_enable) begin
            phase_q       <= phase_q + PHASE_WIDTH'(freq_step);
            sample_tick_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign done        = (state_q == IDLE);
  assign note_active = (state_q == PLAYING) && (note_q != '0);
  assign phase       = phase_q;
  assign sample_tick = sample_tick_q;
endmodule

// File: doc/note_player.md
NOTE_PLAYER -- requirements
Module: note_player

Interface
REQ-001 SHALL have port clk, input, 1, sole clock; all state updates on rising edge.
REQ-002 SHALL have port reset, input, 1, asynchronous active-low reset (asserted at 0).
REQ-003 SHALL have port play_enable, input, 1, global play; 0 freezes counting and phase.
REQ-004 SHALL have port note, input, 6, note index from song reader; 0 = rest.
REQ-005 SHALL have port duration, input, 6, note length in beats.
REQ-006 SHALL have port load_new_note, input, 1, one-cycle pulse qualifying note/duration.
REQ-007 SHALL have port beat, input, 1, one-cycle beat strobe from beat generator.
REQ-008 SHALL have port generate_next_sample, input, 1, one-cycle sample-rate strobe.
REQ-009 SHALL have port done, output, 1, voice free; feeds song reader note_*_done.
REQ-010 SHALL have port note_active, output, 1, voice currently sounding a non-rest note.
REQ-011 SHALL have port phase, output, 22, phase accumulator driving downstream sine lookup.
REQ-012 SHALL have port sample_tick, output, 1, registered pulse marking phase update.

Function
REQ-013 SHALL implement FSM states IDLE and PLAYING; done = (state == IDLE), combinational from state.
REQ-014 IDLE: load_new_note with duration != 0 SHALL latch note into note_q, duration into remaining, clear phase to 0, and enter PLAYING next cycle.
REQ-015 IDLE: load_new_note with duration == 0 SHALL be ignored; state stays IDLE.
REQ-016 PLAYING: load_new_note SHALL be ignored; latched note/remaining unchanged.
REQ-017 PLAYING: beat && play_enable SHALL decrement remaining by 1; if remaining == 1 at that edge, state SHALL return to IDLE (done = 1 next cycle).
REQ-018 beat while play_enable == 0 SHALL be discarded (not counted later).
REQ-019 freq_step SHALL be a 20-bit combinational lookup of note_q via frequency_rom; note_q == 0 yields step 0.
REQ-020 PLAYING: generate_next_sample && play_enable SHALL set phase <= phase + zero-extended freq_step, wrapping modulo 2^22.
REQ-021 sample_tick SHALL be 1 for exactly the cycle after each phase update, else 0.
REQ-022 IDLE: phase SHALL hold; sample_tick SHALL stay 0.
REQ-023 note_active SHALL equal (state == PLAYING) && (note_q != 0).
REQ-024 beat and generate_next_sample in the same cycle SHALL both take effect; on the final beat, the phase update of that edge still applies.
REQ-025 Final beat and load_new_note in the same cycle SHALL NOT load (state is PLAYING); the song reader reloads after done rises.

Reset
REQ-026 reset == 0 SHALL immediately force state IDLE, note_q 0, remaining 0, phase 0, sample_tick 0; hence done 1, note_active 0.
REQ-027 Reset asserted mid-note SHALL abort the note with no further decrement or phase update; first load after release behaves per REQ-014.

Structure
REQ-028 State encodings (IDLE, PLAYING) and widths (NOTE_WIDTH 6, DURATION_WIDTH 6, STEP_WIDTH 20, PHASE_WIDTH 22) SHALL live in the shared defines package used by song_reader.
REQ-029 SHALL instantiate one sub-module frequency_rom: 64-entry combinational table, 6-bit address, 20-bit step, entry 0 = 0.
REQ-030 All registers SHALL use asynchronous active-low reset flops.

Verification
REQ-031 Load note=49, duration=3, play_enable=1, 3 beats -> done 0 for the 3-beat span, done 1 the cycle after third beat, note_active 1 throughout PLAYING.
REQ-032 Load note=0, duration=2 -> done 0 for 2 beats, note_active 0, phase stays 0 across 10 sample strobes.
REQ-033 PLAYING with step S, 4 generate_next_sample strobes -> phase = 4*S mod 2^22, 4 sample_tick pulses each one cycle late; force phase near 2^22-1 -> wraps.
REQ-034 play_enable=0 during 5 beats and 5 sample strobes mid-note -> remaining and phase unchanged; resume completes remaining beats exactly.
REQ-035 Load with duration=0 -> stays IDLE, done 1; load during PLAYING with new note -> ignored, original note_q kept.
REQ-036 Assert reset low after 1 of 4 beats -> done 1, phase 0, sample_tick 0 immediately (before next clock edge).
